// File: rtl/adam_boot_seq.sv
// Boot and run-control sequencer: holds all targets paused after reset, resumes the
// bootstrap-enabled ones in index order, then serves single-target pause/resume commands.
module adam_boot_seq #(
    parameter int unsigned              ADDR_WIDTH     = 32,
    parameter int unsigned              NO_TARGETS     = 4,
    parameter logic [NO_TARGETS-1:0]    EN_BOOTSTRAP   = 4'b0011,
    parameter logic [ADDR_WIDTH-1:0]    RST_BOOT_ADDR  = '0,
    parameter int unsigned              SETTLE_CYCLES  = 5,
    parameter int unsigned              TIMEOUT_CYCLES = 256,
    parameter int unsigned              TW = (NO_TARGETS > 1) ? $clog2(NO_TARGETS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    output logic [NO_TARGETS-1:0]            pause_req_o,
    input  logic [NO_TARGETS-1:0]            pause_ack_i,
    output logic [NO_TARGETS*ADDR_WIDTH-1:0] boot_addr_o,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic [TW-1:0]                    cmd_target_i,
    input  logic                             cmd_pause_i,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr_i,
    output logic                             busy_o,
    output logic                             boot_done_o,
    output logic                             err_o,
    output logic [TW-1:0]                    err_target_o
);

    localparam int unsigned CntMax = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                      : TIMEOUT_CYCLES;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    localparam logic [CW-1:0] SettleLast  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TimeoutLast = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LastIdx     = TW'(NO_TARGETS - 1);

    typedef enum logic [2:0] {
        StResetWait,
        StBootScan,
        StBootWait,
        StIdle,
        StCmdWait
    } state_e;

    state_e                           state_q;
    logic [TW-1:0]                    idx_q;
    logic [CW-1:0]                    cnt_q;
    logic [NO_TARGETS-1:0]            pause_req_q;
    logic [NO_TARGETS*ADDR_WIDTH-1:0] boot_addr_q;
    logic                             boot_done_q;
    logic                             err_q;
    logic [TW-1:0]                    err_target_q;

    logic ack_match;
    logic timeout;
    logic cmd_in_range;

    assign ack_match    = (pause_ack_i[idx_q] == pause_req_q[idx_q]);
    assign timeout      = (cnt_q == TimeoutLast);
    assign cmd_in_range = ({1'b0, cmd_target_i} < (TW + 1)'(NO_TARGETS));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StResetWait;
            idx_q        <= '0;
            cnt_q        <= '0;
            pause_req_q  <= '1;
            boot_addr_q  <= {NO_TARGETS{RST_BOOT_ADDR}};
            boot_done_q  <= 1'b0;
            err_q        <= 1'b0;
            err_target_q <= '0;
        end else begin
            case (state_q)
                StResetWait: begin
                    if (cnt_q == SettleLast) begin
                        state_q <= StBootScan;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StBootScan: begin
                    if (EN_BOOTSTRAP[idx_q]) begin
                        pause_req_q[idx_q] <= 1'b0;
                        cnt_q              <= '0;
                        state_q            <= StBootWait;
                    end else if (idx_q == LastIdx) begin
                        state_q     <= StIdle;
                        boot_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end

                StBootWait: begin
                    // A timeout still advances the scan; the request stays as driven.
                    if (ack_match || timeout) begin
                        if (!ack_match) begin
                            err_q        <= 1'b1;
                            err_target_q <= idx_q;
                        end
                        if (idx_q == LastIdx) begin
                            state_q     <= StIdle;
                            boot_done_q <= 1'b1;
                        end else begin
                            state_q <= StBootScan;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StIdle: begin
                    if (cmd_valid_i) begin
                        if (!cmd_in_range) begin
                            err_q        <= 1'b1;
                            err_target_q <= cmd_target_i;
                        end else begin
                            if (cmd_pause_i) begin
                                pause_req_q[cmd_target_i] <= 1'b1;
                            end else begin
                                pause_req_q[cmd_target_i]                         <= 1'b0;
                                boot_addr_q[cmd_target_i*ADDR_WIDTH +: ADDR_WIDTH] <= cmd_addr_i;
                            end
                            idx_q   <= cmd_target_i;
                            cnt_q   <= '0;
                            state_q <= StCmdWait;
                        end
                    end
                end

                StCmdWait: begin
                    if (ack_match || timeout) begin
                        if (!ack_match) begin
                            err_q        <= 1'b1;
                            err_target_q <= idx_q;
                        end
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: state_q <= StResetWait;
            endcase
        end
    end

    assign pause_req_o  = pause_req_q;
    assign boot_addr_o  = boot_addr_q;
    assign cmd_ready_o  = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign boot_done_o  = boot_done_q;
    assign err_o        = err_q;
    assign err_target_o = err_target_q;

endmodule

// File: tb/tb_adam_boot_seq.sv
// Directed bench for adam_boot_seq: default-style instance with a short timeout, plus a
// three-target instance with no bootstrap targets for range and scan-length checks.
module tb_adam_boot_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: four targets, bootstrap 0011, short timeout.
    logic         rst_na;
    logic [3:0]   req_a;
    logic [3:0]   ack_a;
    logic [127:0] addr_a;
    logic         valid_a;
    logic         ready_a;
    logic [1:0]   tgt_a;
    logic         pause_a;
    logic [31:0]  caddr_a;
    logic         busy_a;
    logic         done_a;
    logic         err_a;
    logic [1:0]   errt_a;

    adam_boot_seq #(
        .ADDR_WIDTH    (32),
        .NO_TARGETS    (4),
        .EN_BOOTSTRAP  (4'b0011),
        .RST_BOOT_ADDR (32'h0000_0000),
        .SETTLE_CYCLES (5),
        .TIMEOUT_CYCLES(8)
    ) u_dut_a (
        .clk_i       (clk),
        .rst_ni      (rst_na),
        .pause_req_o (req_a),
        .pause_ack_i (ack_a),
        .boot_addr_o (addr_a),
        .cmd_valid_i (valid_a),
        .cmd_ready_o (ready_a),
        .cmd_target_i(tgt_a),
        .cmd_pause_i (pause_a),
        .cmd_addr_i  (caddr_a),
        .busy_o      (busy_a),
        .boot_done_o (done_a),
        .err_o       (err_a),
        .err_target_o(errt_a)
    );

    // Instance B: three targets, nothing bootstrapped.
    logic         rst_nb;
    logic [2:0]   req_b;
    logic [2:0]   ack_b;
    logic [95:0]  addr_b;
    logic         valid_b;
    logic         ready_b;
    logic [1:0]   tgt_b;
    logic         pause_b;
    logic [31:0]  caddr_b;
    logic         busy_b;
    logic         done_b;
    logic         err_b;
    logic [1:0]   errt_b;

    adam_boot_seq #(
        .ADDR_WIDTH    (32),
        .NO_TARGETS    (3),
        .EN_BOOTSTRAP  (3'b000),
        .RST_BOOT_ADDR (32'h0000_0000),
        .SETTLE_CYCLES (5),
        .TIMEOUT_CYCLES(8)
    ) u_dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_nb),
        .pause_req_o (req_b),
        .pause_ack_i (ack_b),
        .boot_addr_o (addr_b),
        .cmd_valid_i (valid_b),
        .cmd_ready_o (ready_b),
        .cmd_target_i(tgt_b),
        .cmd_pause_i (pause_b),
        .cmd_addr_i  (caddr_b),
        .busy_o      (busy_b),
        .boot_done_o (done_b),
        .err_o       (err_b),
        .err_target_o(errt_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd_a(input logic [1:0] t, input logic p, input logic [31:0] a);
        tgt_a   = t;
        pause_a = p;
        caddr_a = a;
        valid_a = 1'b1;
        tick(1);
        valid_a = 1'b0;
    endtask

    initial begin
        rst_na = 1'b0; ack_a = 4'b1111; valid_a = 1'b0; tgt_a = '0; pause_a = 1'b0;
        caddr_a = '0;
        rst_nb = 1'b0; ack_b = 3'b111;  valid_b = 1'b0; tgt_b = '0; pause_b = 1'b0;
        caddr_b = '0;
        tick(2);

        // Reset state
        check("rst_req",   req_a,   4'b1111);
        check("rst_addr",  addr_a,  '0);
        check("rst_ready", ready_a, 1'b0);
        check("rst_busy",  busy_a,  1'b1);
        check("rst_done",  done_a,  1'b0);
        check("rst_err",   err_a,   1'b0);
        check("rst_errt",  errt_a,  2'd0);

        // Boot: five settle cycles, then target 0 resumed
        rst_na = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("settle_req", req_a, 4'b1111);
        end
        tick(1);
        check("boot_req0", req_a, 4'b1110);
        tick(2);
        check("boot_hold1", req_a, 4'b1110);
        ack_a = 4'b1110;
        tick(1);
        check("boot_scan1", req_a, 4'b1110);
        tick(1);
        check("boot_req1", req_a, 4'b1100);
        ack_a = 4'b1100;
        tick(2);
        check("boot_notdone", done_a, 1'b0);
        tick(1);
        check("boot_done",  done_a,  1'b1);
        check("boot_ready", ready_a, 1'b1);
        check("boot_busy",  busy_a,  1'b0);
        check("boot_final", req_a,   4'b1100);
        check("boot_err",   err_a,   1'b0);

        // Resume target 2, ack three cycles later
        cmd_a(2'd2, 1'b0, 32'h0010_0000);
        check("res_req",   req_a,          4'b1000);
        check("res_addr2", addr_a[64 +: 32], 32'h0010_0000);
        check("res_ready", ready_a,        1'b0);
        check("res_busy0", busy_a,         1'b1);
        tick(3);
        check("res_busy3", busy_a, 1'b1);
        ack_a = 4'b1000;
        tick(1);
        check("res_idle", busy_a, 1'b0);
        check("res_err",  err_a,  1'b0);

        // Pause target 0, ack never follows -> timeout after 8 cycles
        cmd_a(2'd0, 1'b1, 32'hDEAD_BEEF);
        check("pau_req",   req_a,         4'b1001);
        check("pau_addr0", addr_a[0 +: 32], 32'h0);
        tick(7);
        check("pau_busy7", busy_a, 1'b1);
        check("pau_err7",  err_a,  1'b0);
        tick(1);
        check("pau_idle", busy_a, 1'b0);
        check("pau_err",  err_a,  1'b1);
        check("pau_errt", errt_a, 2'd0);
        check("pau_hold", req_a,  4'b1001);

        // Redundant resume of target 1 completes on the next cycle
        cmd_a(2'd1, 1'b0, 32'hCAFE_0000);
        check("red_busy",  busy_a,          1'b1);
        check("red_addr1", addr_a[32 +: 32], 32'hCAFE_0000);
        tick(1);
        check("red_idle", busy_a, 1'b0);
        check("red_req",  req_a,  4'b1001);

        // Reset during BOOT_WAIT on target 1
        rst_na = 1'b0;
        ack_a  = 4'b1111;
        tick(1);
        rst_na = 1'b1;
        tick(6);
        check("rb_req0", req_a, 4'b1110);
        ack_a = 4'b1110;
        tick(2);
        check("rb_req1", req_a, 4'b1100);
        tick(1);
        rst_na = 1'b0;
        tick(1);
        check("mid_req",  req_a,  4'b1111);
        check("mid_addr", addr_a, '0);
        check("mid_done", done_a, 1'b0);
        check("mid_err",  err_a,  1'b0);
        check("mid_busy", busy_a, 1'b1);
        rst_na = 1'b1;
        ack_a  = 4'b1111;
        tick(5);
        check("rerun_settle", req_a, 4'b1111);
        tick(1);
        check("rerun_req0", req_a, 4'b1110);

        // Instance B: no bootstrap, idle after settle + 3 scan cycles
        rst_nb = 1'b1;
        tick(7);
        check("b_busy7", busy_b, 1'b1);
        check("b_done7", done_b, 1'b0);
        tick(1);
        check("b_idle", busy_b, 1'b0);
        check("b_done", done_b, 1'b1);
        check("b_req",  req_b,  3'b111);
        check("b_err0", err_b,  1'b0);

        // Out-of-range target
        tgt_b   = 2'd3;
        pause_b = 1'b0;
        caddr_b = 32'h1234_5678;
        valid_b = 1'b1;
        tick(1);
        valid_b = 1'b0;
        check("oor_ready", ready_b, 1'b1);
        check("oor_busy",  busy_b,  1'b0);
        check("oor_err",   err_b,   1'b1);
        check("oor_errt",  errt_b,  2'd3);
        check("oor_req",   req_b,   3'b111);
        check("oor_addr",  addr_b,  '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
